// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer: op codes,
// ALU flag bit positions and the sequencer state encoding.
package muldiv_sequencer_pkg;

  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;

  localparam int unsigned ZERO   = 0;
  localparam int unsigned NEG    = 1;
  localparam int unsigned CARRY  = 2;
  localparam int unsigned OVF    = 3;
  localparam int unsigned DIVERR = 4;
  localparam int unsigned SIGN   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFixup,
    StDone
  } state_e;

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add for multiply, compare /
// subtract / shift for restoring divide. Purely combinational.
module muldiv_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_operand,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_div_diff;

  always_comb begin
    w_mul_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : {(WIDTH + 1){1'b0}});
    w_div_shift = {i_hi, i_lo[WIDTH-1]};
    // The true difference always fits WIDTH bits whenever it is taken.
    w_div_diff  = w_div_shift[WIDTH-1:0] - i_operand;
    if (i_is_div) begin
      if (w_div_shift >= {1'b0, i_operand}) begin
        o_hi = w_div_diff;
        o_lo = {i_lo[WIDTH-2:0], 1'b1};
      end else begin
        o_hi = w_div_shift[WIDTH-1:0];
        o_lo = {i_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_hi = w_mul_sum[WIDTH:1];
      o_lo = {w_mul_sum[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer: captures operands on start, runs WIDTH
// unsigned iterations, applies signed fixup and reports results with ALU flags.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] source,
  input  logic [WIDTH-1:0] destination,
  input  logic [15:0]      flags_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic [WIDTH-1:0] result_high,
  output logic [15:0]      flags_out,
  output logic             write_flags
);
  import muldiv_sequencer_pkg::*;

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  state_e r_state, w_state_next;

  logic [CntW-1:0]  r_count;
  logic             r_is_div;
  logic             r_signed;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic             r_div_ovf;
  logic [10:0]      r_flags_keep;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_operand;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_high;
  logic [15:0]      r_flags;

  logic             w_accept;
  logic             w_is_div;
  logic             w_signed;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_src_mag;
  logic [WIDTH-1:0] w_dst_mag;
  logic [15:0]      w_dz_flags;
  logic [WIDTH-1:0] w_step_hi;
  logic [WIDTH-1:0] w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic [15:0]      w_fix_flags;
  logic             w_unused_flags;

  assign w_unused_flags = ^flags_in[4:0];

  // Capture-side decode: magnitudes, divide-by-zero and the lone signed overflow case.
  always_comb begin
    w_accept   = start && is_muldiv_op(op_code);
    w_is_div   = (op_code == OP_DIV);
    w_signed   = flags_in[SIGN];
    w_src_mag  = (w_signed && source[WIDTH-1]) ? -source : source;
    w_dst_mag  = (w_signed && destination[WIDTH-1]) ? -destination : destination;
    w_div_zero = w_is_div && (source == '0);
    w_div_ovf  = w_is_div && w_signed && (destination == MinNeg) && (source == '1);

    w_dz_flags         = '0;
    w_dz_flags[15:5]   = flags_in[15:5];
    w_dz_flags[DIVERR] = 1'b1;
    w_dz_flags[NEG]    = 1'b1;
  end

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_operand(r_operand),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  // Sign fixup: the product is negated as one double-width value, quotient and
  // remainder independently.
  always_comb begin
    w_prod = r_neg_lo ? -{r_hi, r_lo} : {r_hi, r_lo};
    if (r_is_div) begin
      w_fix_lo = r_neg_lo ? -r_lo : r_lo;
      w_fix_hi = r_neg_hi ? -r_hi : r_hi;
    end else begin
      w_fix_lo = w_prod[WIDTH-1:0];
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    end

    w_fix_flags        = '0;
    w_fix_flags[15:5]  = r_flags_keep;
    w_fix_flags[ZERO]  = (w_fix_lo == '0);
    w_fix_flags[NEG]   = w_fix_lo[WIDTH-1];
    w_fix_flags[CARRY] = !r_is_div && (w_fix_hi != '0);
    if (r_is_div) begin
      w_fix_flags[OVF] = r_div_ovf;
    end else if (r_signed) begin
      w_fix_flags[OVF] = (w_fix_hi != {WIDTH{w_fix_lo[WIDTH-1]}});
    end else begin
      w_fix_flags[OVF] = (w_fix_hi != '0);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = w_div_zero ? StDone : StRun;
        end
      end
      StRun: begin
        if (r_count == LastCount) begin
          w_state_next = StFixup;
        end
      end
      StFixup: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count       <= '0;
      r_is_div      <= 1'b0;
      r_signed      <= 1'b0;
      r_neg_lo      <= 1'b0;
      r_neg_hi      <= 1'b0;
      r_div_ovf     <= 1'b0;
      r_flags_keep  <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_operand     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_result_high <= '0;
      r_flags       <= '0;
    end else begin
      r_busy <= (w_state_next == StRun) || (w_state_next == StFixup);
      r_done <= (w_state_next == StDone);
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_count      <= '0;
            r_is_div     <= w_is_div;
            r_signed     <= w_signed;
            r_flags_keep <= flags_in[15:5];
            r_hi         <= '0;
            r_lo         <= w_is_div ? w_dst_mag : w_src_mag;
            r_operand    <= w_is_div ? w_src_mag : w_dst_mag;
            r_neg_lo     <= w_signed && (source[WIDTH-1] ^ destination[WIDTH-1]);
            r_neg_hi     <= w_signed && destination[WIDTH-1];
            r_div_ovf    <= w_div_ovf;
            if (w_div_zero) begin
              r_result      <= '1;
              r_result_high <= destination;
              r_flags       <= w_dz_flags;
            end
          end
        end
        StRun: begin
          r_hi    <= w_step_hi;
          r_lo    <= w_step_lo;
          r_count <= r_count + CntW'(1);
        end
        StFixup: begin
          r_result      <= w_fix_lo;
          r_result_high <= w_fix_hi;
          r_flags       <= w_fix_flags;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign write_flags = r_done;
  assign result_out  = r_result;
  assign result_high = r_result_high;
  assign flags_out   = r_flags;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the 16-bit ALU datapath. The single-cycle ALU returns zero for op codes 0xC (multiply) and 0xD (divide); this block implements both iteratively. It uses a shift-add multiply and a restoring divide, one bit per cycle. It is launched by the control unit with a start/busy/done handshake and returns a result, a high word (product high or remainder) and an updated flags word in the ALU flag layout.

## Interface

Parameters:
- WIDTH, 16: operand width; iteration count equals WIDTH.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- op_code  in  4  0xC multiply, 0xD divide; any other value ignored.
- source  in  WIDTH  multiplier / divisor.
- destination  in  WIDTH  multiplicand / dividend.
- flags_in  in  16  current flags; bit 8 = signed mode.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: results valid.
- result_out  out  WIDTH  product low word / quotient.
- result_high  out  WIDTH  product high word / remainder.
- flags_out  out  16  {flags_in[15:5], divide_error, overflow, carry, negative, zero}.
- write_flags  out  1  equals done.

## Operation

- States: IDLE, RUN, FIXUP, DONE.
- IDLE: start=1 with op_code 0xC/0xD captures operands, op and the sign mode (flags_in[8]) → RUN. Other op codes are ignored (no busy).
- Signed mode: at capture, operands are converted to magnitudes and the result signs are recorded.
- RUN: exactly WIDTH iterations.
  - Multiply: 32-bit shift-add accumulator.
  - Divide: restoring; quotient bit = (partial remainder ≥ divisor).
- After WIDTH iterations → FIXUP.
- FIXUP: in signed mode, negate the results whose recorded sign is negative.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
- FIXUP → DONE.
- DONE: done=1 for one cycle → IDLE. Results and flags hold until the next accepted start.
- Divide by zero (source==0 at capture): RUN and FIXUP are skipped; IDLE → DONE directly.
  - result_out=0xFFFF, result_high=destination, divide_error=1.
- Flags:
  - zero = (result_out==0); negative = result_out[15].
  - Multiply: carry = (unsigned high word ≠ 0). overflow = product does not fit 16 bits in the active mode; in signed mode that means the high word is not the sign extension of result_out.
  - Divide: carry=0. overflow=1 only for signed 0x8000 / 0xFFFF, which returns quotient 0x8000 and remainder 0.
  - flags_in[15:5] pass through unchanged.
- start while busy or in DONE is ignored. Operand inputs need only be valid in the start cycle.
- Reset (asynchronous, any state) → IDLE. busy, done, write_flags, result_out, result_high and flags_out all go to 0. An in-flight operation is discarded.

## Timing

- Start accepted in cycle N: busy=1 in cycles N+1 … N+WIDTH+1. done=1 only in cycle N+WIDTH+2 (N+18 for WIDTH=16), with busy=0.
- Divide by zero: done=1 in cycle N+1; busy stays 0.
- A new start is accepted in the cycle after DONE at the earliest. Throughput is one operation per WIDTH+3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Shared package, alongside the other ALU definitions:
  - OP_MUL=4'hC, OP_DIV=4'hD.
  - Flag bit indices: ZERO=0, NEG=1, CARRY=2, OVF=3, DIVERR=4, SIGN=8.
  - The state enum.
- One natural sub-module: muldiv_step, the combinational single-iteration step (add/shift for multiply; compare/subtract/shift for divide). The sequencer instantiates it once and owns the iteration counter, sign bookkeeping and handshake.

## Test plan

- Unsigned multiply 0x1234 × 0x0010, flags_in=0 → result_out=0x2340, result_high=0x0001, carry=1, overflow=1, zero=0. done exactly 18 cycles after start; busy high for 17 cycles.
- Signed multiply, flags_in[8]=1, source=0xFFFE, destination=0x0003 → result_out=0xFFFA, result_high=0xFFFF, negative=1, overflow=0, carry=1, flags_out[8]=1.
- Divide 0x0064 / 0x0007 unsigned → quotient 0x000E, remainder 0x0002. Signed 0xFFF9 / 0x0002 → quotient 0xFFFD, remainder 0xFFFF. Signed 0x8000 / 0xFFFF → 0x8000, remainder 0, overflow=1.
- Divide by zero, source=0, destination=0x1234 → done in the cycle after start, result_out=0xFFFF, result_high=0x1234, flags_out[4]=1, busy never asserted.
- Handshake:
  - start with op_code=0xA → no busy, no done.
  - Second start during RUN with different operands → ignored; first result unchanged.
  - write_flags tracks done exactly.
- Reset mid-operation: reset_n low in the 8th RUN cycle → all outputs 0 immediately (asynchronous). After release, no done appears. A fresh multiply 3 × 5 then returns 0x000F in 18 cycles.
